// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : MIPS instruction-fetch stage: PC, next-PC selection, IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic [31:0] rs_data,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        addr_err
);

  localparam logic [1:0] c_NPC_PLUS4  = 2'b00;
  localparam logic [1:0] c_NPC_BRANCH = 2'b01;
  localparam logic [1:0] c_NPC_JUMP   = 2'b10;
  localparam logic [1:0] c_NPC_JR     = 2'b11;

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        id_valid_q, id_valid_d;
  logic        addr_err_q, addr_err_d;

  logic        redirect;
  logic [31:0] br_off;
  logic [31:0] target;

  // A bubble in IF/ID carries no control decision, so npc_op is masked by id_valid.
  assign redirect = id_valid_q && (npc_op != c_NPC_PLUS4);
  assign br_off   = {{14{id_instr_q[15]}}, id_instr_q[15:0], 2'b00};

  always_comb begin
    target = pc_q + 32'd4;
    case (npc_op)
      c_NPC_BRANCH: target = id_pc_q + 32'd4 + br_off;
      c_NPC_JUMP:   target = {id_pc_plus4_q[31:28], id_instr_q[25:0], 2'b00};
      c_NPC_JR:     target = {rs_data[31:2], 2'b00};
      default:      target = pc_q + 32'd4;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    addr_err_d    = addr_err_q;
    if (!stall) begin
      if (redirect) begin
        // Wrong-path word at imem_addr is dropped; IF/ID becomes a nop bubble.
        pc_d       = target;
        id_instr_d = 32'h0;
        id_valid_d = 1'b0;
        if ((npc_op == c_NPC_JR) && (rs_data[1:0] != 2'b00)) begin
          addr_err_d = 1'b1;
        end
      end else begin
        pc_d          = pc_q + 32'd4;
        id_instr_d    = imem_rdata;
        id_pc_d       = pc_q;
        id_pc_plus4_d = pc_q + 32'd4;
        id_valid_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      id_instr_q    <= 32'h0;
      id_pc_q       <= 32'h0;
      id_pc_plus4_q <= 32'd4;
      id_valid_q    <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_valid    = id_valid_q;
  assign addr_err    = addr_err_q;

endmodule
`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core; sits directly upstream of the control decoder.
- Owns the PC register and next-PC selection, and drives the instruction-memory address.
- Holds the IF/ID pipeline register. Its id_instr opcode and funct fields feed the decoder.
- Consumes the decoder's NPCOp (00 PLUS4, 01 BRANCH, 10 JUMP, 11 JR/JALR) for the instruction currently held in IF/ID. The branch-taken decision is already folded into NPCOp.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
stall  input  1  hazard hold: freeze PC and IF/ID
npc_op  input  2  NPCOp from decoder for the IF/ID instruction
rs_data  input  32  GPR[rs] of the IF/ID instruction (JR/JALR target)
imem_addr  output  32  instruction-memory address (= pc)
imem_rdata  input  32  instruction word at imem_addr, combinational read
id_instr  output  32  IF/ID instruction register
id_pc  output  32  address of id_instr
id_pc_plus4  output  32  id_pc + 4; link value for JAL/JALR (WDSel FromPC)
id_valid  output  1  id_instr is a real instruction, not a bubble
addr_err  output  1  sticky flag: misaligned JR/JALR target seen

Behaviour:
- Reset (async, rst=1), all outputs forced immediately:
  - pc = RESET_PC, so imem_addr = RESET_PC.
  - id_instr = 32'h0 (sll $0 nop), id_pc = 0, id_pc_plus4 = 4, id_valid = 0, addr_err = 0.
- rst deasserted mid-operation: the first rising edge afterwards performs a normal fetch from RESET_PC.
- Definitions:
  - redirect = id_valid & (npc_op != 2'b00). npc_op is ignored while id_valid = 0.
  - The 11-encoding (JR/JALR) behaves as a redirect exactly like 01 and 10.
- Target computation (combinational, from IF/ID contents):
  - 01 BRANCH: id_pc + 4 + {{14{id_instr[15]}}, id_instr[15:0], 2'b00}, mod 2^32.
  - 10 JUMP: {id_pc_plus4[31:28], id_instr[25:0], 2'b00}.
  - 11 JR: {rs_data[31:2], 2'b00}.
- Per rising edge, first match wins:
  1. stall=1: pc and all IF/ID registers hold; npc_op ignored this cycle; addr_err unchanged.
  2. redirect: pc <= target. IF/ID is flushed: id_instr <= 0, id_valid <= 0, id_pc/id_pc_plus4 hold. The wrong-path word at imem_addr is discarded. No delay slot.
  3. otherwise: id_instr <= imem_rdata, id_pc <= pc, id_pc_plus4 <= pc + 4, id_valid <= 1, pc <= pc + 4.
- pc + 4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000; no error.
- Redirect penalty: exactly one bubble cycle.
- Target instruction timing: appears in IF/ID two edges after the redirecting instruction entered IF/ID.
- addr_err:
  - Set on the edge where a JR redirect (case 2, npc_op = 11) is taken with rs_data[1:0] != 0.
  - Sticky until reset; fetch continues from the aligned target.
- Self-loop: a branch to its own address with offset -1 is legal and must loop forever with one bubble per iteration.

Test Plan:
- Reset then release with imem returning 32'h2008_0005 at 0x3000, npc_op=00 -> after 1 edge: id_instr=32'h2008_0005, id_pc=0x3000, id_pc_plus4=0x3004, id_valid=1, imem_addr=0x3004.
- Taken beq: id_pc=0x3010, imm=0x0003, npc_op=01 -> next edge: pc=0x3020, id_valid=0, id_instr=0. Following edge: id_pc=0x3020, id_valid=1.
- Backward branch: id_pc=0x3008, imm=0xFFFE, npc_op=01 -> pc=0x3004. Jump: id_pc=0x0040_3000, id_instr=0x0810_0000, npc_op=10 -> pc=0x0040_0000.
- jr: npc_op=11, rs_data=0x0000_3106 -> pc=0x0000_3104, addr_err=1. addr_err stays 1 through later aligned jr with rs_data=0x3200; clears only on rst.
- stall=1 for 3 cycles with npc_op=01 present -> pc, id_instr, id_pc unchanged all 3 cycles. First edge after stall=0 performs the redirect.
- pc preloaded via RESET_PC=32'hFFFF_FFFC, npc_op=00 -> after 1 edge: id_pc=0xFFFF_FFFC, id_pc_plus4=0, imem_addr=0. Asserting rst mid-stream forces imem_addr=RESET_PC and id_valid=0 without a clock edge.
